// File: rtl/axis_byte_packer.sv
// Packs an 8-bit AXI-Stream into little-endian OUT_WIDTH-bit words with tkeep/tlast,
// reports the byte count of each completed frame and cuts frames that run past MAX_FRAME.
module axis_byte_packer #(
  parameter int OUT_WIDTH = 32,
  parameter int MAX_FRAME = 768,
  parameter int CNT_W     = 10
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [7:0]             s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tlast,
  output logic [OUT_WIDTH-1:0]   m_axis_tdata,
  output logic [OUT_WIDTH/8-1:0] m_axis_tkeep,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic                   frame_done,
  output logic [CNT_W:0]         frame_bytes,
  output logic                   overrun_err,
  output logic                   dbg_state
);

  localparam int N      = OUT_WIDTH / 8;
  localparam int LANE_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W:0] CNT_LAST = (CNT_W + 1)'(MAX_FRAME - 1);
  localparam logic [CNT_W:0] CNT_MAX  = (CNT_W + 1)'(MAX_FRAME);

  typedef enum logic {FILL = 1'b0, DISCARD = 1'b1} state_t;

  // Handshake rule on both ports: a beat transfers on the rising edge where
  // tvalid && tready; a held beat keeps data/keep/last stable until it transfers.

  state_t               state, state_nxt;
  logic [LANE_W-1:0]    lane;
  logic [CNT_W:0]       cnt;
  logic [OUT_WIDTH-1:0] acc;
  logic                 rst_done;
  logic                 out_free, lane_full, at_max, completes;
  logic                 accept, load;
  logic [OUT_WIDTH-1:0] word_nxt;
  logic [N-1:0]         keep_nxt;

  assign out_free   = !m_axis_tvalid || m_axis_tready;
  assign lane_full  = (lane == LANE_W'(N - 1));
  assign at_max     = (cnt == CNT_LAST);
  assign completes  = lane_full || s_axis_tlast || at_max;
  assign frame_done = m_axis_tvalid && m_axis_tready && m_axis_tlast;
  assign dbg_state  = state;

  // Upper lanes of acc are always zero, so OR-ing in the new byte yields the padded word.
  assign word_nxt = acc | (OUT_WIDTH'(s_axis_tdata) << (8 * lane));

  always_comb begin
    keep_nxt = '0;
    for (int k = 0; k < N; k++) keep_nxt[k] = (LANE_W'(k) <= lane);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= FILL;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (accept && at_max && !s_axis_tlast) state_nxt = DISCARD;
      DISCARD: if (accept && s_axis_tlast)            state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_comb begin
    s_axis_tready = 1'b0;
    if (rst_done) begin
      case (state)
        FILL:    s_axis_tready = completes ? out_free : 1'b1;
        DISCARD: s_axis_tready = 1'b1;
        default: s_axis_tready = 1'b0;
      endcase
    end
    accept = s_axis_tvalid && s_axis_tready;
    load   = accept && (state == FILL) && completes;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rst_done      <= 1'b0;
      lane          <= '0;
      cnt           <= '0;
      acc           <= '0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      frame_bytes   <= '0;
      overrun_err   <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;
      if (load) begin
        m_axis_tdata  <= word_nxt;
        m_axis_tkeep  <= keep_nxt;
        m_axis_tlast  <= s_axis_tlast || at_max;
        m_axis_tvalid <= 1'b1;
      end
      if (accept && (state == FILL)) begin
        if (completes) begin
          lane <= '0;
          acc  <= '0;
        end else begin
          lane <= lane + 1'b1;
          acc  <= word_nxt;
        end
        if (s_axis_tlast) begin
          frame_bytes <= cnt + 1'b1;
          cnt         <= '0;
        end else if (at_max) begin
          frame_bytes <= CNT_MAX;
          overrun_err <= 1'b1;
          cnt         <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_byte_packer.sv
// Bench for axis_byte_packer: frame table plus hand-built corner sequences,
// checked against an expected-word queue filled as bytes are accepted.
module tb_axis_byte_packer;

  localparam int MAX_FRAME = 768;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        frame_done;
  logic [10:0] frame_bytes;
  logic        overrun_err;
  logic        dbg_state;

  axis_byte_packer #(.OUT_WIDTH(32), .MAX_FRAME(MAX_FRAME), .CNT_W(10)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .frame_done(frame_done),
    .frame_bytes(frame_bytes), .overrun_err(overrun_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 aclk = ~aclk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int          errors = 0;
  int          checks = 0;
  logic [36:0] exp_q[$];   // {tlast, tkeep, tdata}
  int          words_seen = 0;
  int          done_seen  = 0;
  bit          model_on   = 1'b1;
  bit          stall_en   = 1'b0;
  bit          force_low  = 1'b0;
  int          m_lane, m_cnt;
  bit          m_disc;
  logic [31:0] m_acc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_lane = 0; m_cnt = 0; m_disc = 1'b0; m_acc = '0;
    exp_q.delete();
  endtask

  task automatic model_accept(input logic [7:0] d, input logic l);
    bit fin;
    if (m_disc) begin
      if (l) m_disc = 1'b0;
    end else begin
      m_acc[8*m_lane +: 8] = d;
      m_lane++;
      m_cnt++;
      fin = l || (m_cnt == MAX_FRAME);
      if (m_lane == 4 || fin) begin
        if (model_on) exp_q.push_back({fin, 4'((1 << m_lane) - 1), m_acc});
        if (!l && m_cnt == MAX_FRAME) m_disc = 1'b1;
        if (fin) m_cnt = 0;
        m_lane = 0;
        m_acc  = '0;
      end
    end
  endtask

  // ---------------- monitor ----------------
  logic [36:0] prev_out;
  bit          prev_stall = 1'b0;

  always @(negedge aclk) begin
    logic [36:0] e;
    if (!aresetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && m_axis_tvalid)
        check("stall_hold", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, prev_out);
      if (m_axis_tvalid && m_axis_tready) begin
        words_seen++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word: got 0x%0h expected none",
                   {m_axis_tlast, m_axis_tkeep, m_axis_tdata});
        end else begin
          e = exp_q.pop_front();
          check("word", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, e);
          check("frame_done_on_word", frame_done, e[36]);
        end
      end else if (frame_done) begin
        checks++; errors++;
        $display("FAIL frame_done_spurious: got 1 expected 0");
      end
      if (frame_done) done_seen++;
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_out   = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
    end
  end

  // ---------------- drivers ----------------
  initial begin
    int cyc;
    cyc = 0;
    m_axis_tready = 1'b1;
    forever begin
      @(posedge aclk); #1;
      cyc++;
      m_axis_tready = stall_en ? ((cyc % 16) >= 10) : !force_low;
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic l);
    bit pred;
    int budget;
    if ($urandom_range(0, 7) == 0) begin
      s_axis_tvalid = 1'b0;
      @(posedge aclk); #1;
    end
    pred = !m_disc && (m_lane == 3 || l || m_cnt == MAX_FRAME - 1);
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    budget = 0;
    forever begin
      @(negedge aclk);
      if (s_axis_tready) break;
      checks++;
      if (!pred) begin
        errors++;
        $display("FAIL s_ready_low: got 0 expected 1 for byte 0x%0h", d);
      end
      budget++;
      if (budget > 200) begin
        errors++;
        $display("FAIL accept_timeout: got no handshake expected handshake for byte 0x%0h", d);
        s_axis_tvalid = 1'b0;
        return;
      end
    end
    @(posedge aclk); #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    model_accept(d, l);
  endtask

  task automatic send_frame(input int len, input int last_at, input logic [7:0] base);
    for (int i = 0; i < len; i++) send_byte(8'(int'(base) + i), (i == last_at));
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 3000) begin
      @(posedge aclk); #2;
      b++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    repeat (2) @(posedge aclk);
    #1;
  endtask

  // ---------------- frame table ----------------
  typedef struct {
    int          len;
    int          last_at;
    logic [7:0]  base;
    bit          stall;
    int          exp_words;
    logic [10:0] exp_fb;
    logic        exp_ovr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int w0, d0;
    vecs[0] = '{768, 767, 8'h00, 1'b0, 192, 11'd768, 1'b0};
    vecs[1] = '{768, 767, 8'h00, 1'b1, 192, 11'd768, 1'b0};
    vecs[2] = '{7,   6,   8'h10, 1'b0, 2,   11'd7,   1'b0};
    vecs[3] = '{8,   7,   8'h30, 1'b1, 2,   11'd8,   1'b0};
    vecs[4] = '{800, 799, 8'h00, 1'b0, 192, 11'd768, 1'b1};
    vecs[5] = '{4,   3,   8'hE0, 1'b0, 1,   11'd4,   1'b1};

    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    model_reset();

    // reset state
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_s_ready", s_axis_tready, 0);
    check("rst_m_valid", m_axis_tvalid, 0);
    check("rst_outputs", {m_axis_tdata, m_axis_tkeep, m_axis_tlast, frame_done}, 0);
    check("rst_frame_bytes", frame_bytes, 0);
    check("rst_overrun", overrun_err, 0);
    aresetn = 1'b1;
    #1;
    check("rel_s_ready_before_clk", s_axis_tready, 0);
    @(posedge aclk); #1;
    check("rel_s_ready_after_clk", s_axis_tready, 1);

    // 5-byte frame: full word then a 1-lane tail
    model_on = 1'b0;
    exp_q.push_back({1'b0, 4'hF, 32'hA3A2A1A0});
    exp_q.push_back({1'b1, 4'h1, 32'h000000A4});
    for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i), (i == 4));
    check("t2_latency_valid", m_axis_tvalid, 1);
    check("t2_latency_keep", m_axis_tkeep, 4'h1);
    drain();
    check("t2_frame_bytes", frame_bytes, 5);
    model_on = 1'b1;

    for (int i = 0; i < 6; i++) begin
      w0 = words_seen; d0 = done_seen;
      stall_en = vecs[i].stall;
      send_frame(vecs[i].len, vecs[i].last_at, vecs[i].base);
      drain();
      stall_en = 1'b0;
      check($sformatf("v%0d_words", i), words_seen - w0, vecs[i].exp_words);
      check($sformatf("v%0d_frame_done", i), done_seen - d0, 1);
      check($sformatf("v%0d_frame_bytes", i), frame_bytes, vecs[i].exp_fb);
      check($sformatf("v%0d_overrun", i), overrun_err, vecs[i].exp_ovr);
    end

    // reset mid-frame with a word held at the output
    force_low = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    for (int i = 0; i < 6; i++) send_byte(8'h60 + 8'(i), 1'b0);
    #3 aresetn = 1'b0;
    #1;
    check("t5_m_valid", m_axis_tvalid, 0);
    check("t5_outputs", {m_axis_tdata, m_axis_tkeep, m_axis_tlast, frame_done}, 0);
    check("t5_s_ready", s_axis_tready, 0);
    check("t5_overrun_cleared", overrun_err, 0);
    check("t5_frame_bytes", frame_bytes, 0);
    model_reset();
    @(posedge aclk); #3;
    aresetn = 1'b1;
    force_low = 1'b0;
    @(posedge aclk); #1;
    w0 = words_seen;
    model_on = 1'b0;
    exp_q.push_back({1'b1, 4'h7, 32'h00CCBBAA});
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b1);
    drain();
    check("t5_words", words_seen - w0, 1);
    check("t5_frame_bytes_after", frame_bytes, 3);

    // single-byte frame back-to-back with a 4-byte frame
    w0 = words_seen; d0 = done_seen;
    exp_q.push_back({1'b1, 4'h1, 32'h0000005A});
    exp_q.push_back({1'b1, 4'hF, 32'h44332211});
    send_byte(8'h5A, 1'b1);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b1);
    drain();
    check("t6_words", words_seen - w0, 2);
    check("t6_frame_done", done_seen - d0, 2);
    check("t6_frame_bytes", frame_bytes, 4);
    check("t6_overrun", overrun_err, 0);
    model_on = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
